// File: rtl/measure_display_pkg.sv
// Shared constants for the measurement display: segment codes, FSM states and the
// double-dabble step used by the binary-to-BCD engine.
package measure_display_pkg;

  localparam int unsigned MEAS_W = 14;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned SR_W   = BCD_W + MEAS_W;
  localparam int unsigned SHIFTS = MEAS_W;

  // Active-low segments, bit 0 = segment a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (t[MEAS_W + 4*i +: 4] >= 4'd5) begin
        t[MEAS_W + 4*i +: 4] = t[MEAS_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/measure_display_seg7_decode.sv
// Digit to active-low seven-segment decoder; codes above 9 show a dash.
module seg7_decode
  import measure_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/measure_display.sv
// Periodically captures the measurement result, converts it to BCD with a serial
// double-dabble engine and drives HEX4..HEX0 (value) and HEX5 (channel).
module measure_display
  import measure_display_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter int unsigned NUM_W          = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NUM_W-1:0] num,
  input  logic [2:0]       measurement,
  input  logic [1:0]       waveSel,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        refresh_q, refresh_d;
  logic                    pending_q, pending_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [3:0]              shift_cnt_q, shift_cnt_d;
  logic [2:0]              meas_q, meas_d;
  logic [1:0]              wave_q, wave_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [5:0][6:0]         hex_q, hex_d;

  logic                    refresh_hit;
  logic                    trigger;
  logic                    start;
  logic [DIGITS-1:0][3:0]  digit;
  logic [5:0]              blank;
  logic                    lead_zero;
  logic [3:0]              chan_digit;
  logic [5:0][6:0]         seg;

  assign refresh_hit = (refresh_q == CNT_W'(REFRESH_CYCLES - 1));
  assign trigger     = load | refresh_hit;
  assign start       = trigger | pending_q;
  assign refresh_d   = refresh_hit ? '0 : refresh_q + CNT_W'(1);

  // State register plus all datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      refresh_q   <= '0;
      pending_q   <= 1'b0;
      sr_q        <= '0;
      shift_cnt_q <= '0;
      meas_q      <= '0;
      wave_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hex_q       <= {6{SEG_BLANK}};
    end else begin
      state_q     <= state_d;
      refresh_q   <= refresh_d;
      pending_q   <= pending_d;
      sr_q        <= sr_d;
      shift_cnt_q <= shift_cnt_d;
      meas_q      <= meas_d;
      wave_q      <= wave_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hex_q       <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SHIFT;
      ST_SHIFT:  if (shift_cnt_q == 4'(SHIFTS - 1)) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Register next-values for each state; triggers while converting merge into pending
  always_comb begin
    pending_d   = pending_q;
    sr_d        = sr_q;
    shift_cnt_d = shift_cnt_q;
    meas_d      = meas_q;
    wave_d      = wave_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hex_d       = hex_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d        = {BCD_W'(0), MEAS_W'(num)};
          meas_d      = measurement;
          wave_d      = waveSel;
          shift_cnt_d = '0;
          busy_d      = 1'b1;
          pending_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        sr_d        = dabble_step(sr_q);
        shift_cnt_d = shift_cnt_q + 4'd1;
        pending_d   = pending_q | trigger;
      end
      ST_UPDATE: begin
        hex_d     = seg;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        pending_d = pending_q | trigger;
      end
      default: begin
        pending_d = pending_q | trigger;
      end
    endcase
  end

  assign digit = sr_q[SR_W-1 -: BCD_W];

  // Leading-zero blanking from HEX4 down to HEX1; a zero measurement mode blanks everything
  always_comb begin
    blank     = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero & (digit[i] == 4'd0);
      blank[i]  = (meas_q == 3'd0) | lead_zero;
    end
    blank[0] = (meas_q == 3'd0);
    blank[5] = (meas_q == 3'd0);
  end

  always_comb begin
    chan_digit = 4'hF;
    case (wave_q)
      2'd0:    chan_digit = 4'd1;
      2'd1:    chan_digit = 4'd2;
      default: chan_digit = 4'hF;
    endcase
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    seg7_decode u_dec (
      .digit_i (digit[g]),
      .blank_i (blank[g]),
      .seg_o   (seg[g])
    );
  end

  seg7_decode u_dec_chan (
    .digit_i (chan_digit),
    .blank_i (blank[5]),
    .seg_o   (seg[5])
  );

  assign busy = busy_q;
  assign done = done_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_measure_display.sv
// Randomized and directed bench for measure_display against a countdown-based reference model.
module tb_measure_display;

  localparam int unsigned RC = 64;

  logic        clock = 1'b0;
  logic        reset, load;
  logic [13:0] num;
  logic [2:0]  measurement;
  logic [1:0]  waveSel;
  logic        busy, done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  always #5 clock = ~clock;

  measure_display #(.REFRESH_CYCLES(RC), .NUM_W(14)) dut (
    .clock(clock), .reset(reset), .num(num), .measurement(measurement),
    .waveSel(waveSel), .load(load), .busy(busy), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_cnt, m_rem, cap_num, cap_meas, cap_wave;
  bit         m_pend, m_busy, m_done;
  logic [6:0] m_hex[6];
  int         done_cnt, tick_no, last_done_tick, first_done_tick;
  logic [6:0] done_hex0[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic model_display();
    int v, p;
    v = cap_num;
    if (cap_meas == 0) begin
      for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
    end else begin
      p = 1;
      for (int i = 0; i < 5; i++) begin
        m_hex[i] = (i > 0 && v < p) ? 7'h7F : seg_of((v / p) % 10);
        p = p * 10;
      end
      m_hex[5] = (cap_wave == 0) ? seg_of(1) : (cap_wave == 1) ? seg_of(2) : 7'b0111111;
    end
  endtask

  task automatic model_step(input bit r, input bit l, input int n, input int m, input int w);
    bit trig;
    if (r) begin
      m_cnt = 0; m_rem = 0; m_pend = 0; m_busy = 0; m_done = 0;
      for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
      return;
    end
    trig   = l || (m_cnt == int'(RC) - 1);
    m_cnt  = (m_cnt + 1) % int'(RC);
    m_done = 0;
    if (m_rem == 0) begin
      if (trig || m_pend) begin
        cap_num = n; cap_meas = m; cap_wave = w;
        m_rem = 15; m_busy = 1; m_pend = 0;
      end
    end else begin
      if (trig) m_pend = 1;
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
        model_display();
      end
    end
  endtask

  task automatic tick(input bit r, input bit l, input int n, input int m, input int w);
    logic [6:0] dh[6];
    reset = r; load = l; num = 14'(n); measurement = 3'(m); waveSel = 2'(w);
    model_step(r, l, n, m, w);
    @(negedge clock);
    tick_no++;
    dh = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    for (int i = 0; i < 6; i++) check_eq($sformatf("hex%0d", i), 32'(dh[i]), 32'(m_hex[i]));
    if (done === 1'b1) begin
      if (done_cnt == 0) first_done_tick = tick_no;
      done_cnt++;
      last_done_tick = tick_no;
      done_hex0.push_back(HEX0);
    end
  endtask

  task automatic clear_stats();
    done_cnt = 0; tick_no = 0; last_done_tick = 0; first_done_tick = 0;
    done_hex0.delete();
  endtask

  task automatic idle(input int cycles, input int n, input int m, input int w);
    for (int i = 0; i < cycles; i++) tick(0, 0, n, m, w);
  endtask

  initial begin
    int n, m, w;
    bit r, l;
    int picks[10];
    picks = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};
    clear_stats();

    // 1: zero shows a single 0, channel 1
    tick(1, 0, 0, 1, 0);
    tick(1, 0, 0, 1, 0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hex0", 32'(HEX0), 32'h7F);
    tick(0, 1, 0, 1, 0);
    idle(15, 0, 1, 0);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_hex0", 32'(HEX0), 32'b1000000);
    check_eq("t1_hex1", 32'(HEX1), 32'h7F);
    check_eq("t1_hex4", 32'(HEX4), 32'h7F);
    check_eq("t1_hex5", 32'(HEX5), 32'b1111001);

    // 2: full scale
    tick(0, 1, 16383, 1, 0);
    idle(15, 16383, 1, 0);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_hex4", 32'(HEX4), 32'b1111001);
    check_eq("t2_hex3", 32'(HEX3), 32'b0000010);
    check_eq("t2_hex2", 32'(HEX2), 32'b0110000);
    check_eq("t2_hex1", 32'(HEX1), 32'b0000000);
    check_eq("t2_hex0", 32'(HEX0), 32'b0110000);

    // 3: internal zero kept, channel 2
    tick(0, 1, 1204, 1, 1);
    idle(15, 1204, 1, 1);
    check_eq("t3_hex4", 32'(HEX4), 32'h7F);
    check_eq("t3_hex3", 32'(HEX3), 32'b1111001);
    check_eq("t3_hex2", 32'(HEX2), 32'b0100100);
    check_eq("t3_hex1", 32'(HEX1), 32'b1000000);
    check_eq("t3_hex0", 32'(HEX0), 32'b0011001);
    check_eq("t3_hex5", 32'(HEX5), 32'b0100100);

    // 4: load during a busy conversion becomes a pending second conversion
    tick(1, 0, 1234, 1, 0);
    clear_stats();
    tick(0, 1, 1234, 1, 0);
    idle(4, 1234, 1, 0);
    tick(0, 1, 4321, 1, 0);
    idle(40, 4321, 1, 0);
    check_eq("t4_dones", 32'(done_cnt), 32'd2);
    if (done_hex0.size() == 2) begin
      check_eq("t4_first", 32'(done_hex0[0]), 32'b0011001);
      check_eq("t4_second", 32'(done_hex0[1]), 32'b1111001);
      check_eq("t4_gap", 32'(last_done_tick - first_done_tick), 32'd16);
    end

    // 5: measurement 0 blanks everything; free-running refresh every RC cycles
    tick(1, 0, 999, 0, 0);
    clear_stats();
    idle(220, 999, 0, 0);
    check_eq("t5_dones", 32'(done_cnt), 32'd3);
    check_eq("t5_first", 32'(first_done_tick), 32'd79);
    check_eq("t5_period", 32'(last_done_tick - first_done_tick), 32'(2 * RC));
    check_eq("t5_hex0", 32'(HEX0), 32'h7F);

    // 6: reset mid-conversion aborts it
    tick(1, 0, 4321, 1, 0);
    tick(0, 1, 4321, 1, 0);
    idle(6, 4321, 1, 0);
    tick(1, 0, 4321, 1, 0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_hex0", 32'(HEX0), 32'h7F);
    clear_stats();
    idle(40, 4321, 1, 0);
    check_eq("t6_dones", 32'(done_cnt), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 9)] : int'($urandom_range(0, 16383));
      m = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 7));
      w = int'($urandom_range(0, 3));
      tick(r, l, n, m, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
